// File: rtl/spike_packetizer_pkg.sv
// Shared types and packet layout for the spike packetizer and the downstream router.
// Packet format: {dest, neuron index}, dest in the MSBs.
package spike_packetizer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NUM_NEURONS_DEF = 256;
    localparam int IDX_W_DEF       = 8;

    // Router-side field layout at the default index width
    localparam int DEST_W       = 8;
    localparam int PKT_IDX_LSB  = 0;
    localparam int PKT_DEST_LSB = IDX_W_DEF;
    localparam int PKT_W        = DEST_W + IDX_W_DEF;

endpackage

// File: rtl/spike_scan_counter.sv
// Neuron index register for the frame scan; saturates at NUM_NEURONS-1 and flags it.
module spike_scan_counter #(
    parameter int NUM_NEURONS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    assign last = (idx == IDX_W'(NUM_NEURONS - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (inc && !last) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/spike_packetizer.sv
// Turns a latched frame of neuron spike bits into {dest, index} packets, one per set bit,
// in ascending index order. Define SPIKE_COUNT_EN to add the per-frame spike_count_o output.
module spike_packetizer
    import spike_packetizer_pkg::*;
#(
    parameter int NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_NEURONS-1:0]  spikes_i,
    input  logic [DEST_W-1:0]       dest_i,
    input  logic                    frame_valid_i,
    output logic                    frame_ready_o,
    output logic [DEST_W+IDX_W-1:0] packet_o,
    output logic                    packet_valid_o,
    input  logic                    packet_ready_i,
    output logic                    frame_done_o
`ifdef SPIKE_COUNT_EN
    ,
    output logic [IDX_W:0]          spike_count_o
`endif
);

    state_t                   state, next_state;
    logic [NUM_NEURONS-1:0]   spikes_q;
    logic [DEST_W-1:0]        dest_q;
    logic [IDX_W-1:0]         idx;
    logic                     last;
    logic                     accept, cur_bit, handshake, inc;

    assign accept    = (state == IDLE) && frame_valid_i;
    assign cur_bit   = spikes_q[idx];
    assign handshake = (state == SEND) && packet_ready_i;
    assign inc       = ((state == SCAN) && !cur_bit) || handshake;

    spike_scan_counter #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_scan_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .inc     (inc),
        .idx     (idx),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (frame_valid_i) next_state = SCAN;
            SCAN: begin
                if (cur_bit)   next_state = SEND;
                else if (last) next_state = DONE;
            end
            SEND: if (packet_ready_i) next_state = last ? DONE : SCAN;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        frame_ready_o  = (state == IDLE);
        packet_valid_o = (state == SEND);
        frame_done_o   = (state == DONE);
    end

    // packet_o only loads in SCAN, so it holds steady for the whole SEND stall
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spikes_q <= '0;
            dest_q   <= '0;
            packet_o <= '0;
        end else begin
            if (accept) begin
                spikes_q <= spikes_i;
                dest_q   <= dest_i;
            end
            if ((state == SCAN) && cur_bit) packet_o <= {dest_q, idx};
        end
    end

`ifdef SPIKE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n)       spike_count_o <= '0;
        else if (accept)    spike_count_o <= '0;
        else if (handshake) spike_count_o <= spike_count_o + 1'b1;
    end
`endif

endmodule

// File: doc/spike_packetizer.md
SPIKE_PACKETIZER -- requirements
Module: spike_packetizer

Interface
REQ-001 Parameter NUM_NEURONS, 256, number of neuron spike bits per frame (power of two, max 256).
REQ-002 Parameter IDX_W, 8, neuron index width (log2 NUM_NEURONS).
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port spikes_i  input  NUM_NEURONS  spike_o bits of the neuron array, bit n = neuron n.
REQ-006 Port dest_i  input  8  destination core address for this frame's packets.
REQ-007 Port frame_valid_i  input  1  spikes_i/dest_i valid (end of timestep).
REQ-008 Port frame_ready_o  output  1  block idle, can accept a frame.
REQ-009 Port packet_o  output  8+IDX_W  packet {dest, neuron index}; dest in MSBs.
REQ-010 Port packet_valid_o  output  1  packet_o valid.
REQ-011 Port packet_ready_i  input  1  downstream router accepts packet.
REQ-012 Port frame_done_o  output  1  one-cycle pulse, all packets of the frame sent.

Function
REQ-013 FSM states IDLE, SCAN, SEND, DONE; IDLE after reset.
REQ-014 frame_ready_o = 1 only in IDLE.
REQ-015 IDLE: frame_valid_i=1 in cycle T -> spikes_i and dest_i latched, index counter = 0, SCAN entered at T+1.
REQ-016 SCAN: one index examined per cycle; latched bit clear -> index+1, stay in SCAN; bit set -> packet_o = {dest, index} registered, SEND next cycle.
REQ-017 SEND: packet_valid_o = 1, packet_o stable until handshake (packet_valid_o and packet_ready_i in the same cycle).
REQ-018 On handshake: index+1 and SCAN next cycle; if index = NUM_NEURONS-1, DONE next cycle instead.
REQ-019 SCAN with clear bit at index NUM_NEURONS-1 -> DONE next cycle.
REQ-020 DONE lasts exactly one cycle with frame_done_o = 1, then IDLE.
REQ-021 Packets emitted in ascending index order; exactly one packet per set bit; no duplicates, no omissions.
REQ-022 packet_valid_o never deasserts before handshake; packet_ready_i with packet_valid_o = 0 has no effect.
REQ-023 frame_valid_i outside IDLE ignored; latched data unaffected by later spikes_i changes.
REQ-024 Index counter never wraps; NUM_NEURONS-1 is terminal.
REQ-025 All-zero frame: frame_done_o at T+1+NUM_NEURONS (T = accept cycle), no packets.
REQ-026 First packet (bit 0 set): packet_valid_o high at T+2.

Reset
REQ-027 reset_n = 0 at a rising edge: state IDLE, index 0, latched data 0, packet_o 0, packet_valid_o 0, frame_done_o 0, frame_ready_o 1 from the next cycle.
REQ-028 Reset mid-frame aborts the frame; a pending packet is dropped with no frame_done_o.

Configuration
REQ-029 Macro SPIKE_COUNT_EN defined: output spike_count_o [IDX_W:0] added; cleared on frame accept; +1 per handshake; final value valid from the frame_done_o cycle until the next accept; reset 0.
REQ-030 SPIKE_COUNT_EN undefined: no spike_count_o port, no counter logic; all other behaviour identical.

Structure
REQ-031 Shared package holds the FSM state enum, NUM_NEURONS/IDX_W defaults, and the packet field width/offset constants used by the router.
REQ-032 Single file; one optional sub-module spike_scan_counter (index register, increment, terminal flag); no FIFO.

Verification
REQ-033 spikes_i = 0, frame_valid_i pulse at T -> no packet_valid_o, frame_done_o exactly at T+257, frame_ready_o high at T+258.
REQ-034 Bits 0, 5, 255 set, dest 0x3A, ready tied 1 -> packets 0x3A00, 0x3A05, 0x3AFF in order, first at T+2, then frame_done_o (count = 3 with SPIKE_COUNT_EN).
REQ-035 Bit 7 set, packet_ready_i held 0 for 10 cycles -> packet_valid_o and packet_o = {dest,0x07} stable for all 10 cycles, single transfer on release.
REQ-036 All 256 bits set, random ready backpressure -> 256 packets, indices 0..255, one frame_done_o.
REQ-037 frame_valid_i reasserted with new spikes_i mid-frame -> ignored, output matches first frame only.
REQ-038 reset_n low for 1 cycle while in SEND -> packet_valid_o 0 next cycle, no frame_done_o, next frame processed normally.
